// File: rtl/round_key_store_pkg.sv
// Shared widths, FSM state type and small helpers for the round key store.
package round_key_store_pkg;

   localparam int NB             = 4;
   localparam int ROUND_KEY_BITS = 128;
   localparam int AES_MAX_ROUNDS = 14;
   localparam int RAM_DEPTH      = AES_MAX_ROUNDS + 1;

   typedef logic [NB-1:0]             round_idx_t;
   typedef logic [ROUND_KEY_BITS-1:0] round_key_t;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_LOADING,
      ST_READY,
      ST_STREAM
   } rks_state_t;

   function automatic logic idx_in_range(input round_idx_t idx);
      return idx <= round_idx_t'(AES_MAX_ROUNDS);
   endfunction

   // A rounds_total beyond the RAM depth would walk past the last entry.
   function automatic round_idx_t clamp_rounds(input round_idx_t rounds);
      return idx_in_range(rounds) ? rounds : round_idx_t'(AES_MAX_ROUNDS);
   endfunction

endpackage

// File: rtl/round_key_store_if.sv
// Round key output stream from the store to the cipher datapath.
interface round_key_store_if;
   import round_key_store_pkg::*;

   // A key moves on every clock edge where rk_valid && rk_ready. Once rk_valid
   // is raised, rk_data/rk_index/rk_last hold stable until that transfer; the
   // source never waits on rk_ready before raising rk_valid.
   logic       rk_valid;
   logic       rk_ready;
   round_key_t rk_data;
   round_idx_t rk_index;
   logic       rk_last;

   modport master (
      output rk_valid,
      output rk_data,
      output rk_index,
      output rk_last,
      input  rk_ready
   );

   modport slave (
      input  rk_valid,
      input  rk_data,
      input  rk_index,
      input  rk_last,
      output rk_ready
   );

endinterface

// File: rtl/round_key_store_ram.sv
// 15 x 128-bit key RAM: one write port, one synchronous read port, no reset.
module round_key_ram
   import round_key_store_pkg::*;
(
   input  logic       clk,
   input  logic       wr_en,
   input  round_idx_t wr_addr,
   input  round_key_t wr_data,
   input  round_idx_t rd_addr,
   output round_key_t rd_data
);

   round_key_t mem [RAM_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/round_key_store.sv
// Stores an expanded AES key schedule and streams it to the cipher in
// ascending (encrypt) or descending (decrypt) round order.
module round_key_store
   import round_key_store_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     w_e,
   input  round_idx_t               round_key_addr,
   input  round_key_t               round_key,
   input  logic                     key_done,
   input  round_idx_t               rounds_total,
   input  logic                     invalidate,
   input  logic                     start,
   input  logic                     decrypt,
   output logic                     key_ready,
   output logic                     busy,
   round_key_store_if.master        rk,
   output rks_state_t               dbg_state
);

   rks_state_t state_q, state_d;
   round_idx_t rounds_q;
   round_idx_t idx_q;
   round_idx_t next_idx;
   round_idx_t first_idx;
   round_idx_t rd_addr;
   logic       desc_q;
   logic       valid_q;
   logic       is_last;
   logic       xfer;
   logic       ram_we;
   logic       latch_rounds;
   logic       begin_stream;
   round_key_t ram_q;

   // Read address runs one key ahead on a transfer so the synchronous RAM
   // output is already the next key on the following cycle; on a stall it
   // re-reads the current entry, which keeps rk_data steady.
   always_comb begin
      first_idx = decrypt ? rounds_q : '0;
      is_last   = desc_q ? (idx_q == '0) : (idx_q == rounds_q);
      next_idx  = desc_q ? (idx_q - round_idx_t'(1)) : (idx_q + round_idx_t'(1));
      xfer      = valid_q && rk.rk_ready;
      rd_addr   = (xfer && !is_last) ? next_idx : idx_q;
   end

   always_comb begin
      state_d      = state_q;
      ram_we       = 1'b0;
      latch_rounds = 1'b0;
      begin_stream = 1'b0;
      if (invalidate) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (w_e && idx_in_range(round_key_addr)) begin
                  ram_we  = 1'b1;
                  state_d = ST_LOADING;
               end
            end
            ST_LOADING: begin
               ram_we = w_e && idx_in_range(round_key_addr);
               if (key_done) begin
                  latch_rounds = 1'b1;
                  state_d      = ST_READY;
               end
            end
            ST_READY: begin
               if (start) begin
                  begin_stream = 1'b1;
                  state_d      = ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (xfer && is_last) begin
                  state_d = ST_READY;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_EMPTY;
         rounds_q <= '0;
         idx_q    <= '0;
         desc_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (latch_rounds) begin
            rounds_q <= clamp_rounds(rounds_total);
         end
         if (begin_stream) begin
            desc_q <= decrypt;
            idx_q  <= first_idx;
         end else if (state_q == ST_STREAM) begin
            idx_q <= rd_addr;
         end
         // First cycle in STREAM only issues the read, hence valid one cycle later.
         valid_q <= (state_q == ST_STREAM) && (state_d == ST_STREAM);
      end
   end

   round_key_ram u_ram (
      .clk     (clk),
      .wr_en   (ram_we && !reset),
      .wr_addr (round_key_addr),
      .wr_data (round_key),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );

   assign key_ready   = (state_q == ST_READY) || (state_q == ST_STREAM);
   assign busy        = (state_q == ST_STREAM);
   assign dbg_state   = state_q;
   assign rk.rk_valid = valid_q;
   assign rk.rk_index = idx_q;
   assign rk.rk_last  = valid_q && is_last;
   assign rk.rk_data  = valid_q ? ram_q : '0;

endmodule
